// File: rtl/sha256_padder.sv
// SHA-256 message padder: 32-bit word stream in, 512-bit chunks out.
// Define SHA256_PADDER_ERR_EN to add the sticky err output for illegal msg_bytes.
module sha256_padder #(
  parameter int LEN_BYTES_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msg_vld,
  output logic              msg_rdy,
  input  logic [31:0]       msg_data,
  input  logic              msg_last,
  input  logic [2:0]        msg_bytes,
  output logic              chunk_vld,
  input  logic              chunk_rdy,
  output logic [15:0][31:0] chunk_data,
  output logic              chunk_last
`ifdef SHA256_PADDER_ERR_EN
  ,
  output logic              err
`endif
);

  typedef enum logic {S_FILL, S_EMIT} state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0][31:0]      r_buf;
  logic [3:0]             r_idx;
  logic [LEN_BYTES_W-1:0] r_cnt;
  logic                   r_pend80;
  logic                   r_extra;
  logic                   r_last;

  logic                   w_acc;
  logic                   w_hs;
  logic [2:0]             w_b;
  logic [31:0]            w_word;
  logic [LEN_BYTES_W-1:0] w_cnt_nx;
  logic [6:0]             w_p;
  logic [63:0]            w_len_nx;
  logic [63:0]            w_len;

  assign w_acc = msg_vld & msg_rdy;
  assign w_hs  = chunk_vld & chunk_rdy;

  // Non-last beats always carry 4 bytes; oversize counts clamp to 4.
  always_comb begin
    w_b = 3'd4;
    if (msg_last && msg_bytes < 3'd4)
      w_b = msg_bytes;
  end

  // Keep the valid bytes and drop the 0x80 marker right after them.
  always_comb begin
    w_word = msg_data;
    case (w_b)
      3'd0:    w_word = 32'h8000_0000;
      3'd1:    w_word = {msg_data[31:24], 24'h80_0000};
      3'd2:    w_word = {msg_data[31:16], 16'h8000};
      3'd3:    w_word = {msg_data[31:8], 8'h80};
      default: w_word = msg_data;
    endcase
  end

  assign w_cnt_nx = r_cnt + LEN_BYTES_W'(w_b);
  assign w_p      = {1'b0, r_idx, 2'b00} + 7'(w_b);
  assign w_len_nx = 64'(w_cnt_nx) << 3;
  assign w_len    = 64'(r_cnt) << 3;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FILL;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      r_state == S_FILL:
        if (w_acc && (msg_last || r_idx == 4'd15))
          w_next = S_EMIT;
      r_state == S_EMIT:
        if (w_hs && !r_extra)
          w_next = S_FILL;
      default: w_next = S_FILL;
    endcase
  end

  always_comb begin
    msg_rdy    = (r_state == S_FILL) & ~rst;
    chunk_vld  = (r_state == S_EMIT);
    chunk_data = r_buf;
    chunk_last = r_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf    <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_pend80 <= 1'b0;
      r_extra  <= 1'b0;
      r_last   <= 1'b0;
    end else if (r_state == S_FILL) begin
      if (w_acc) begin
        r_buf[r_idx] <= w_word;
        r_cnt        <= w_cnt_nx;
        r_last       <= 1'b0;
        if (!msg_last) begin
          r_idx <= r_idx + 4'd1;
        end else begin
          r_idx <= '0;
          if (w_b == 3'd4 && r_idx != 4'd15)
            r_buf[r_idx + 4'd1] <= 32'h8000_0000;
          if (w_p <= 7'd55) begin
            r_buf[14] <= w_len_nx[63:32];
            r_buf[15] <= w_len_nx[31:0];
            r_last    <= 1'b1;
          end else begin
            r_extra  <= 1'b1;
            r_pend80 <= (w_p == 7'd64);
          end
        end
      end
    end else if (w_hs) begin
      r_buf <= '0;
      if (r_extra) begin
        r_buf[0]  <= r_pend80 ? 32'h8000_0000 : 32'h0;
        r_buf[14] <= w_len[63:32];
        r_buf[15] <= w_len[31:0];
        r_last    <= 1'b1;
        r_extra   <= 1'b0;
        r_pend80  <= 1'b0;
      end else begin
        r_idx  <= '0;
        r_last <= 1'b0;
        if (r_last)
          r_cnt <= '0;
      end
    end
  end

`ifdef SHA256_PADDER_ERR_EN
  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if (w_acc && (msg_bytes > 3'd4 ||
                       (msg_bytes != 3'd4 && !msg_last)))
      err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: directed and random messages vs a byte-level
// FIPS 180-4 padding model, with randomized chunk backpressure.
module tb_sha256_padder;

  logic              clk = 1'b0;
  logic              rst;
  logic              msg_vld;
  logic              msg_rdy;
  logic [31:0]       msg_data;
  logic              msg_last;
  logic [2:0]        msg_bytes;
  logic              chunk_vld;
  logic              chunk_rdy;
  logic [15:0][31:0] chunk_data;
  logic              chunk_last;
`ifdef SHA256_PADDER_ERR_EN
  logic              err;
`endif

  int checks   = 0;
  int failures = 0;

  byte unsigned      g_msg[$];
  logic [15:0][31:0] exp_q[$];

  always #5 clk = ~clk;

  sha256_padder dut (
    .clk        (clk),
    .rst        (rst),
    .msg_vld    (msg_vld),
    .msg_rdy    (msg_rdy),
    .msg_data   (msg_data),
    .msg_last   (msg_last),
    .msg_bytes  (msg_bytes),
    .chunk_vld  (chunk_vld),
    .chunk_rdy  (chunk_rdy),
    .chunk_data (chunk_data),
    .chunk_last (chunk_last)
`ifdef SHA256_PADDER_ERR_EN
    ,
    .err        (err)
`endif
  );

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Standard padding on the byte string, then cut into 64-byte chunks.
  task automatic build_exp();
    byte unsigned      pb[$];
    longint unsigned   bl;
    logic [15:0][31:0] ch;
    pb = g_msg;
    pb.push_back(8'h80);
    while (pb.size() % 64 != 56) pb.push_back(8'h00);
    bl = 64'(g_msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) pb.push_back(8'(bl >> (8 * i)));
    exp_q.delete();
    for (int c = 0; c < pb.size() / 64; c++) begin
      for (int w = 0; w < 16; w++)
        ch[w] = {pb[c*64+4*w], pb[c*64+4*w+1],
                 pb[c*64+4*w+2], pb[c*64+4*w+3]};
      exp_q.push_back(ch);
    end
  endtask

  task automatic rand_msg(input int n);
    g_msg.delete();
    for (int i = 0; i < n; i++) g_msg.push_back(8'($urandom));
  endtask

  // mode 0: always ready, 1: random ready, 2: stall first chunk 10 cycles
  task automatic run_msg(input int mode, input bit bad);
    int n;
    int nb;
    int bi;
    int ci;
    int cyc;
    int stall;
    int idx;
    bit prev_stall;
    logic [15:0][31:0] prev;
    n  = g_msg.size();
    nb = (n == 0) ? 1 : (n + 3) / 4;
    bi = 0; ci = 0; cyc = 0; stall = 0; prev_stall = 0;
    prev = '0;
    build_exp();
    while ((bi < nb || ci < exp_q.size()) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (mode == 0)      chunk_rdy = 1'b1;
      else if (mode == 1) chunk_rdy = 1'($urandom_range(0, 1));
      else                chunk_rdy = (stall >= 10);
      if (chunk_vld) begin
        chk("no_overlap_rdy", 512'(msg_rdy), 512'(0));
        if (prev_stall) chk("hold_data", chunk_data, prev);
        if (ci >= exp_q.size()) begin
          chk("extra_chunk", 512'(chunk_vld), 512'(0));
          chunk_rdy = 1'b1;
        end else if (chunk_rdy) begin
          chk("chunk_data", chunk_data, exp_q[ci]);
          chk("chunk_last", 512'(chunk_last),
              512'(ci == exp_q.size() - 1));
          ci++;
          prev_stall = 0;
        end else begin
          prev = chunk_data;
          prev_stall = 1;
          stall++;
        end
      end
      if (msg_rdy && bi < nb) begin
        for (int k = 0; k < 4; k++) begin
          idx = 4 * bi + k;
          msg_data[31-8*k -: 8] = (idx < n) ? g_msg[idx] : 8'($urandom);
        end
        msg_last  = (bi == nb - 1);
        msg_bytes = msg_last ? 3'(n - 4 * bi) : 3'd4;
        if (bad && bi == 0 && !msg_last) msg_bytes = 3'd2;
        msg_vld = 1'b1;
        bi++;
      end else begin
        msg_vld   = 1'b0;
        msg_data  = $urandom;
        msg_last  = 1'($urandom);
        msg_bytes = 3'($urandom);
      end
    end
    chk("chunks_done", 512'(ci), 512'(exp_q.size()));
    @(negedge clk);
    msg_vld   = 1'b0;
    chunk_rdy = 1'b0;
    chk("idle_vld", 512'(chunk_vld), 512'(0));
    chk("idle_rdy", 512'(msg_rdy), 512'(1));
  endtask

  initial begin
    rst       = 1'b1;
    msg_vld   = 1'b0;
    msg_data  = '0;
    msg_last  = 1'b0;
    msg_bytes = 3'd0;
    chunk_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_msg_rdy", 512'(msg_rdy), 512'(0));
    chk("rst_chunk_vld", 512'(chunk_vld), 512'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 512'(msg_rdy), 512'(1));
    chk("post_rst_last", 512'(chunk_last), 512'(0));
    chk("post_rst_data", chunk_data, 512'(0));
`ifdef SHA256_PADDER_ERR_EN
    chk("err_init", 512'(err), 512'(0));
`endif

    g_msg = '{8'h61, 8'h62, 8'h63};
    run_msg(0, 0);
    g_msg.delete();
    run_msg(0, 0);
    rand_msg(56);
    run_msg(0, 0);
    rand_msg(64);
    run_msg(0, 0);
    rand_msg(20);
    run_msg(2, 0);
    rand_msg(64);
    run_msg(2, 0);
    foreach (exp_q[i]) begin end
    for (int n = 52; n <= 66; n++) begin
      rand_msg(n);
      run_msg(1, 0);
    end

    // Abort a message midway with reset, then send "abc".
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      msg_vld   = 1'b1;
      msg_data  = $urandom;
      msg_last  = 1'b0;
      msg_bytes = 3'd4;
    end
    @(negedge clk);
    msg_vld = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    chk("abort_rst_rdy", 512'(msg_rdy), 512'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("abort_vld", 512'(chunk_vld), 512'(0));
    chk("abort_data", chunk_data, 512'(0));
    g_msg = '{8'h61, 8'h62, 8'h63};
    run_msg(1, 0);

    for (int t = 0; t < 12; t++) begin
      rand_msg($urandom_range(0, 200));
      run_msg(1, 0);
    end

`ifdef SHA256_PADDER_ERR_EN
    chk("err_clean", 512'(err), 512'(0));
    rand_msg(10);
    run_msg(0, 1);
    chk("err_set", 512'(err), 512'(1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
